rx_wb_pack: RTL and testbench

RX_WB_PACK -- requirements
Module: rx_wb_pack

---
 rtl/rx_wb_pack_pkg.sv | 18 +
 rtl/rx_frame_fifo.sv | 57 +++++
 rtl/rx_wb_pack.sv | 146 ++++++++++++++
 tb/tb_rx_wb_pack.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_wb_pack_pkg.sv
`default_nettype none
// rx_wb_pack_pkg -- word-count constants and sequencer state encoding shared by the RX word packer. Rev 1.0
package rx_wb_pack_pkg;

  localparam int NARROW_WPC = 2;
  localparam int WIDE_WPC   = 3;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } seq_state_e;

  function automatic logic [1:0] last_word_idx(input logic wide);
    return wide ? 2'(WIDE_WPC - 1) : 2'(NARROW_WPC - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rx_frame_fifo.sv
`default_nettype none
// rx_frame_fifo -- frame FIFO with a registered read port; rd_data_o holds the last popped frame. Rev 1.0
module rx_frame_fifo #(
  parameter int WIDTH = 144,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_full_cnt = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             w_push, w_pop;

  assign full_o  = (count_q == c_full_cnt);
  assign empty_o = (count_q == '0);
  // A write into a full FIFO is taken only when a read frees the slot in the same cycle.
  assign w_pop   = rd_en_i && !empty_o;
  assign w_push  = wr_en_i && (!full_o || w_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop) begin
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        rd_data_q <= mem_q[rd_ptr_q];
      end
      count_q <= count_q + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = rd_data_q;
  assign level_o   = count_q;

endmodule
`default_nettype wire

// File: rtl/rx_wb_pack.sv
`default_nettype none
// rx_wb_pack -- buffers multi-channel I/Q frames and serialises them as 16-bit words. Rev 1.0
module rx_wb_pack
  import rx_wb_pack_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int IN_WIDTH = 18,
  parameter int DEPTH    = 16
) (
  input  logic                      adc_clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      mode,
  input  logic                      in_strobe,
  input  logic [NCH*IN_WIDTH-1:0]   in_i,
  input  logic [NCH*IN_WIDTH-1:0]   in_q,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [15:0]               out_data,
  output logic [2:0]                out_chan,
  output logic                      out_last,
  output logic [15:0]               ovfl_cnt,
  output logic [$clog2(DEPTH):0]    fifo_level
);

  localparam int FW = 2 * NCH * IN_WIDTH;

  seq_state_e           state_q, state_d;
  logic [2:0]           chan_q, chan_d;
  logic [1:0]           word_q, word_d;
  logic                 mode_q, mode_d;
  logic [15:0]          ovfl_q;
  logic                 w_push_req, w_pop, w_full, w_empty, w_drop;
  logic                 w_word_last, w_chan_last;
  logic [FW-1:0]        w_frame;
  logic [IN_WIDTH-1:0]  w_i, w_q;
  logic [15:0]          w_word;

  function automatic logic [7:0] sext_hi(input logic [IN_WIDTH-1:0] s);
    logic [23:0] e;
    e = 24'($signed(s));
    return e[23:16];
  endfunction

  assign w_push_req = in_strobe && enable;
  assign w_drop     = w_push_req && w_full && !w_pop;

  rx_frame_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i     (adc_clk),
    .rst_ni    (reset_n),
    .wr_en_i   (w_push_req),
    .wr_data_i ({in_q, in_i}),
    .rd_en_i   (w_pop),
    .rd_data_o (w_frame),
    .full_o    (w_full),
    .empty_o   (w_empty),
    .level_o   (fifo_level)
  );

  assign w_word_last = (word_q == last_word_idx(mode_q));
  assign w_chan_last = (chan_q == 3'(NCH - 1));

  always_ff @(posedge adc_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      chan_q  <= '0;
      word_q  <= '0;
      mode_q  <= 1'b0;
      ovfl_q  <= '0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      word_q  <= word_d;
      mode_q  <= mode_d;
      if (w_drop && ovfl_q != 16'hFFFF) ovfl_q <= ovfl_q + 16'd1;
    end
  end

  // Popping on the final handshake keeps back-to-back frames bubble-free; mode is sampled only at pop.
  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    word_d  = word_q;
    mode_d  = mode_q;
    w_pop   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop   = 1'b1;
          state_d = ST_EMIT;
          chan_d  = '0;
          word_d  = '0;
          mode_d  = mode;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          if (!w_word_last) begin
            word_d = word_q + 2'd1;
          end else begin
            word_d = '0;
            if (!w_chan_last) begin
              chan_d = chan_q + 3'd1;
            end else begin
              chan_d = '0;
              if (!w_empty) begin
                w_pop  = 1'b1;
                mode_d = mode;
              end else begin
                state_d = ST_IDLE;
              end
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign w_i = w_frame[int'(chan_q) * IN_WIDTH +: IN_WIDTH];
  assign w_q = w_frame[NCH * IN_WIDTH + int'(chan_q) * IN_WIDTH +: IN_WIDTH];

  always_comb begin
    w_word = '0;
    if (!mode_q) begin
      w_word = (word_q == 2'd0) ? w_i[IN_WIDTH-1 -: 16] : w_q[IN_WIDTH-1 -: 16];
    end else begin
      case (word_q)
        2'd0:    w_word = w_i[15:0];
        2'd1:    w_word = w_q[15:0];
        default: w_word = {sext_hi(w_i), sext_hi(w_q)};
      endcase
    end
  end

  assign out_valid = (state_q == ST_EMIT);
  assign out_data  = out_valid ? w_word : 16'h0000;
  assign out_chan  = chan_q;
  assign out_last  = out_valid && w_word_last && w_chan_last;
  assign ovfl_cnt  = ovfl_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_wb_pack.sv
`default_nettype none
// tb_rx_wb_pack -- directed self-checking bench for rx_wb_pack (NCH=4, IN_WIDTH=18, DEPTH=4). Rev 1.0
module tb_rx_wb_pack;

  localparam int NCH   = 4;
  localparam int IW    = 18;
  localparam int DEPTH = 4;

  logic                 clk = 1'b0;
  logic                 reset_n, enable, mode, in_strobe, out_ready;
  logic [NCH*IW-1:0]    in_i, in_q;
  logic                 out_valid, out_last;
  logic [15:0]          out_data, ovfl_cnt;
  logic [2:0]           out_chan;
  logic [$clog2(DEPTH):0] fifo_level;

  always #5 clk = ~clk;

  rx_wb_pack #(.NCH(NCH), .IN_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .adc_clk    (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .mode       (mode),
    .in_strobe  (in_strobe),
    .in_i       (in_i),
    .in_q       (in_q),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_chan   (out_chan),
    .out_last   (out_last),
    .ovfl_cnt   (ovfl_cnt),
    .fifo_level (fifo_level)
  );

  int n_err = 0;
  int n_chk = 0;

  logic [15:0] cap_d[$];
  logic [2:0]  cap_c[$];
  logic        cap_l[$];

  localparam logic [NCH*IW-1:0] F1_I = {18'h00004, 18'h00000, 18'h12345, 18'h1FFFF};
  localparam logic [NCH*IW-1:0] F1_Q = {18'h2FFFC, 18'h3FFFF, 18'h3ABCD, 18'h20000};

  logic [15:0] exp_n[8]  = '{16'h7FFF, 16'h8000, 16'h48D1, 16'hEAF3,
                             16'h0000, 16'hFFFF, 16'h0001, 16'hBFFF};
  logic [15:0] exp_w[12] = '{16'hFFFF, 16'h0000, 16'h01FE,
                             16'h2345, 16'hABCD, 16'h01FF,
                             16'h0000, 16'hFFFF, 16'h00FF,
                             16'h0004, 16'hFFFC, 16'h00FE};
  int exp_first[5] = '{2, 3, 4, 5, 8};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe_frame(input logic [NCH*IW-1:0] vi, input logic [NCH*IW-1:0] vq);
    in_i      = vi;
    in_q      = vq;
    in_strobe = 1'b1;
    tick();
    in_strobe = 1'b0;
  endtask

  function automatic logic [NCH*IW-1:0] frame_k(input int k);
    logic [NCH*IW-1:0] v;
    v = '0;
    v[IW-1:0] = 18'(k * 4);
    return v;
  endfunction

  // Collects one frame with out_ready held high; optionally flips mode at a word or strobes on the last word.
  task automatic capture(input int flip_at, input bit strobe_last);
    int  n = 0;
    int  budget = 200;
    bit  done = 1'b0;
    cap_d.delete();
    cap_c.delete();
    cap_l.delete();
    out_ready = 1'b1;
    while (!done && budget > 0) begin
      if (out_valid) begin
        cap_d.push_back(out_data);
        cap_c.push_back(out_chan);
        cap_l.push_back(out_last);
        if (n == flip_at) mode = 1'b1;
        if (out_last) begin
          done = 1'b1;
          if (strobe_last) in_strobe = 1'b1;
        end
        n++;
      end
      tick();
      in_strobe = 1'b0;
      budget--;
    end
    if (!done) check("capture_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_f1(input bit wide);
    int nw  = wide ? 12 : 8;
    int wpc = wide ? 3 : 2;
    check(wide ? "wide_len" : "narrow_len", cap_d.size(), nw);
    for (int k = 0; k < cap_d.size() && k < nw; k++) begin
      if (wide) check($sformatf("wide_word%0d", k), cap_d[k], exp_w[k]);
      else      check($sformatf("narrow_word%0d", k), cap_d[k], exp_n[k]);
      check($sformatf("chan%0d", k), cap_c[k], k / wpc);
      check($sformatf("last%0d", k), cap_l[k], (k == nw - 1));
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_valid"}, out_valid, 0);
    check({pfx, "_data"},  out_data, 0);
    check({pfx, "_chan"},  out_chan, 0);
    check({pfx, "_last"},  out_last, 0);
    check({pfx, "_ovfl"},  ovfl_cnt, 0);
    check({pfx, "_level"}, fifo_level, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int budget;
    reset_n = 1'b0; enable = 1'b0; mode = 1'b0; in_strobe = 1'b0;
    in_i = '0; in_q = '0; out_ready = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    reset_n = 1'b1;
    enable  = 1'b1;
    tick();

    // Narrow frame and strobe-to-valid latency
    out_ready = 1'b1;
    strobe_frame(F1_I, F1_Q);
    check("latency_t1", out_valid, 0);
    tick();
    check("latency_t2", out_valid, 1);
    capture(-1, 1'b0);
    check_f1(1'b0);

    // Wide frame
    mode = 1'b1;
    strobe_frame(F1_I, F1_Q);
    capture(-1, 1'b0);
    check_f1(1'b1);
    mode = 1'b0;

    // Strobes with enable low are ignored
    enable = 1'b0;
    seen   = 0;
    repeat (3) begin
      strobe_frame(F1_I, F1_Q);
      if (out_valid) seen++;
    end
    repeat (6) begin
      tick();
      if (out_valid) seen++;
    end
    check("disabled_valid_cycles", seen, 0);
    check("disabled_level", fifo_level, 0);
    check("disabled_ovfl", ovfl_cnt, 0);
    enable = 1'b1;

    // Overflow with a stalled consumer, then push+pop while full
    out_ready = 1'b0;
    for (int k = 1; k <= 7; k++) strobe_frame(frame_k(k), '0);
    repeat (2) tick();
    check("full_level", fifo_level, 4);
    check("full_ovfl", ovfl_cnt, 2);
    check("full_valid", out_valid, 1);
    check("full_word0", out_data, 1);
    tick();
    check("stall_hold_data", out_data, 1);
    check("stall_hold_chan", out_chan, 0);
    check("stall_hold_last", out_last, 0);
    in_i = frame_k(8);
    capture(-1, 1'b1);
    check("frame1_len", cap_d.size(), 8);
    check("frame1_word0", cap_d[0], 1);
    check("pushpop_full_level", fifo_level, 4);
    check("pushpop_full_ovfl", ovfl_cnt, 2);
    for (int f = 0; f < 5; f++) begin
      capture(-1, 1'b0);
      check($sformatf("drain%0d_len", f), cap_d.size(), 8);
      check($sformatf("drain%0d_word0", f), cap_d[0], exp_first[f]);
    end
    tick();
    check("drained_valid", out_valid, 0);
    check("drained_level", fifo_level, 0);

    // Mode change mid-frame applies from the next frame; enable low keeps queued frames
    out_ready = 1'b0;
    mode = 1'b0;
    strobe_frame(F1_I, F1_Q);
    strobe_frame(F1_I, F1_Q);
    enable = 1'b0;
    capture(3, 1'b0);
    check_f1(1'b0);
    capture(-1, 1'b0);
    check_f1(1'b1);
    mode   = 1'b0;
    enable = 1'b1;

    // Reset in the middle of a frame with two frames queued
    out_ready = 1'b0;
    repeat (3) strobe_frame(F1_I, F1_Q);
    budget = 20;
    while (!out_valid && budget > 0) begin
      tick();
      budget--;
    end
    check("prerst_valid", out_valid, 1);
    check("prerst_level", fifo_level, 2);
    out_ready = 1'b1;
    repeat (5) tick();
    check("prerst_word5", out_data, exp_n[5]);
    reset_n = 1'b0;
    #1;
    check_all_zero("midrst");
    repeat (2) tick();
    reset_n = 1'b1;
    seen = 0;
    repeat (4) begin
      tick();
      if (out_valid) seen++;
    end
    check("postrst_valid_cycles", seen, 0);
    check("postrst_level", fifo_level, 0);
    strobe_frame(frame_k(9), '0);
    capture(-1, 1'b0);
    check("postrst_len", cap_d.size(), 8);
    check("postrst_word0", cap_d[0], 9);
    check("postrst_chan0", cap_c[0], 0);
    check("postrst_ovfl", ovfl_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
